// File: rtl/mem_bus_master_pkg.sv
// Shared memory-bus definitions: device selects, address split, FSM states,
// and the registered request record.
package mem_bus_master_pkg;

  // Device select codes driven onto address[15:12]
  localparam logic [3:0] MainMemEn  = 4'h0;
  localparam logic [3:0] InstrMemEn = 4'h1;
  localparam logic [3:0] AluEn      = 4'h2;

  localparam int DEV_W      = 4;
  localparam int OFFS_W     = 12;
  localparam int MBM_DATA_W = 256;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} mbm_state_t;

  typedef struct packed {
    logic                  write;
    logic [DEV_W-1:0]      dev;
    logic [OFFS_W-1:0]     addr;
    logic [1:0]            len;
    logic [MBM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_master_wait_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module mbm_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)          cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator: converts single requests into one-cycle nRead/nWrite strobes
// on the shared memory bus (devices act on negedge Clk), captures read data
// after WAIT_STATES cycles and reports each beat with a resp_valid pulse.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DATA_W      = MBM_DATA_W,
  parameter int ADDR_W      = DEV_W + OFFS_W
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DEV_W-1:0]  req_dev,
  input  logic [OFFS_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_last,
  output logic [ADDR_W-1:0] address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] BusDataOut,
  input  logic [DATA_W-1:0] BusDataIn
);

  // Timer is loaded on the STROBE->WAIT edge, so it counts WAIT_STATES-1 .. 0
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  mbm_state_t state_q, state_d;
  mem_req_t   req_q;
  logic [1:0] beat_q;
  logic       accept, tmr_load, tmr_done, last_beat, wr_nxt;

  mbm_wait_timer #(.CNT_W(3)) u_wait (
    .Clk      (Clk),
    .nReset   (nReset),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .done     (tmr_done)
  );

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, acceptance and timer load
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    tmr_load = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = STROBE;
      end
      STROBE: if (WAIT_STATES == 0) state_d = RESP;
              else begin
                state_d  = WAIT;
                tmr_load = 1'b1;
              end
      WAIT:   if (tmr_done) state_d = RESP;
      RESP:   state_d = last_beat ? IDLE : STROBE;
      default: state_d = IDLE;
    endcase
  end

  // Writes are stored as len=0 so beat bookkeeping is shared with reads
  assign last_beat = (beat_q == req_q.len);
  assign wr_nxt    = accept ? req_write : req_q.write;

  // Request register; offset steps (wrapping within the device) between beats
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      req_q  <= '0;
      beat_q <= '0;
    end else if (accept) begin
      req_q  <= '{write: req_write, dev: req_dev, addr: req_addr,
                  len: req_write ? 2'd0 : req_len, wdata: req_wdata};
      beat_q <= '0;
    end else if (state_q == RESP && !last_beat) begin
      req_q.addr <= req_q.addr + 1'b1;
      beat_q     <= beat_q + 1'b1;
    end
  end

  // Strobes registered from next state so each is low for exactly the STROBE cycle
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      nRead  <= 1'b1;
      nWrite <= 1'b1;
    end else begin
      nRead  <= !(state_d == STROBE && !wr_nxt);
      nWrite <= !(state_d == STROBE &&  wr_nxt);
    end
  end

  // Read data capture on the edge leaving the last STROBE/WAIT cycle of a beat
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)
      resp_rdata <= '0;
    else if (!req_q.write && state_q != RESP && state_d == RESP)
      resp_rdata <= BusDataIn;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_last  = resp_valid && last_beat;
  assign address    = ADDR_W'({req_q.dev, req_q.addr});
  assign BusDataOut = (state_q != IDLE && req_q.write) ? DATA_W'(req_q.wdata) : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: three instances (WAIT_STATES 1, 0, 3) share one
// negedge-acting memory device; a cycle-level reference model predicts outputs.
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  typedef struct packed {
    logic [4:0]   ctl;   // {req_ready, nRead, nWrite, resp_valid, resp_last}
    logic [15:0]  addr;
    logic [255:0] rdata;
    logic [255:0] dout;
  } snap_t;

  function automatic int ws(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  logic Clk = 1'b0;
  logic nReset = 1'b1;
  always #5 Clk = ~Clk;

  logic         req_write;
  logic [3:0]   req_dev;
  logic [11:0]  req_addr;
  logic [1:0]   req_len;
  logic [255:0] req_wdata;
  logic         vld [3];
  logic         rdy [3], nrd [3], nwr [3], rv [3], rl [3];
  logic [15:0]  adr [3];
  logic [255:0] rdat [3], dout [3], bdin [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_bus_master #(.WAIT_STATES(ws(gi))) u_dut (
      .Clk(Clk), .nReset(nReset), .req_valid(vld[gi]), .req_ready(rdy[gi]),
      .req_write(req_write), .req_dev(req_dev), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata), .resp_valid(rv[gi]),
      .resp_rdata(rdat[gi]), .resp_last(rl[gi]), .address(adr[gi]),
      .nRead(nrd[gi]), .nWrite(nwr[gi]), .BusDataOut(dout[gi]), .BusDataIn(bdin[gi])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  // Memory device: acts on negedge; contents cleared by bumping cur_gen
  function automatic logic [255:0] dev_init(logic [15:0] a);
    return 256'((int'(a[11:0]) * 7) % 16);
  endfunction

  int unsigned  cur_gen = 1;
  int unsigned  dgen [0:65535];
  logic [255:0] dmem [0:65535];

  always @(negedge Clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!nwr[k]) begin
        dmem[adr[k]] <= dout[k];
        dgen[adr[k]] <= cur_gen;
      end
      if (!nrd[k]) bdin[k] <= (dgen[adr[k]] == cur_gen) ? dmem[adr[k]] : dev_init(adr[k]);
    end
  end

  // Reference model state
  logic [255:0] ref_mem [logic [15:0]];
  logic [255:0] last_rd [3];
  snap_t        obs_q [$];
  snap_t        exp_q [$];
  bit           chka_q [$];

  function automatic logic [255:0] ref_rd(logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dev_init(a);
  endfunction

  // Expected per-cycle outputs from cycle 1 (after acceptance) to the IDLE cycle after the last beat
  task automatic model(int k, bit wr, logic [3:0] dev, logic [11:0] a, logic [1:0] len, logic [255:0] wd);
    int w = ws(k);
    int beats = wr ? 1 : int'(len) + 1;
    snap_t e;
    logic [11:0] off;
    exp_q.delete();
    chka_q.delete();
    for (int c = 1; c <= beats * (w + 2); c++) begin
      int b = (c - 1) / (w + 2);
      int p = (c - 1) % (w + 2);
      bit stb = (p == 0);
      bit rsp = (p == w + 1);
      off = a + 12'(b);
      if (rsp && !wr) last_rd[k] = ref_rd({dev, off});
      e.ctl   = {1'b0, !(stb && !wr), !(stb && wr), rsp, rsp && (b == beats - 1)};
      e.addr  = {dev, off};
      e.rdata = last_rd[k];
      e.dout  = wr ? wd : 256'd0;
      exp_q.push_back(e);
      chka_q.push_back(1'b1);
    end
    e.ctl = 5'b11100; e.addr = '0; e.rdata = last_rd[k]; e.dout = '0;
    exp_q.push_back(e);
    chka_q.push_back(1'b0);
    if (wr) ref_mem[{dev, a}] = wd;
  endtask

  // Present a request; returns #1 after the accepting edge (cycle 1)
  task automatic issue(int k, bit wr, logic [3:0] dev, logic [11:0] a, logic [1:0] len, logic [255:0] wd, bit hold);
    req_write = wr; req_dev = dev; req_addr = a; req_len = len; req_wdata = wd;
    vld[k] = 1'b1;
    @(posedge Clk); #1;
    if (!hold) begin
      vld[k] = 1'b0;
      req_write = 1'($urandom); req_dev = 4'($urandom); req_addr = 12'($urandom);
      req_len = 2'($urandom); req_wdata = {8{$urandom}};
    end
  endtask

  task automatic capture(int k, int n);
    snap_t s;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge Clk); #1; end
      s.ctl = {rdy[k], nrd[k], nwr[k], rv[k], rl[k]};
      s.addr = adr[k]; s.rdata = rdat[k]; s.dout = dout[k];
      obs_q.push_back(s);
    end
  endtask

  task automatic test_reset;
    #1 nReset = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({rdy[k], nrd[k], nwr[k], rv[k], rl[k]} !== 5'b11100) begin
        n_fail++; $display("FAIL reset ctl inst %0d: got %b exp 11100", k, {rdy[k], nrd[k], nwr[k], rv[k], rl[k]});
      end
      n_chk++;
      if ({adr[k], rdat[k], dout[k]} !== '0) begin
        n_fail++; $display("FAIL reset data inst %0d: addr %h rdata %h dout %h exp all 0", k, adr[k], rdat[k], dout[k]);
      end
    end
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    @(negedge Clk) nReset = 1'b1;
    #1;
    n_chk++;
    if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL reset release ready: got %b exp 1", rdy[0]); end
  endtask

  task automatic test_write;
    for (int t = 0; t < 2; t++) begin
      bit wr = (t == 0);
      model(0, wr, MainMemEn, 12'h002, 2'd0, 256'hA5);
      issue(0, wr, MainMemEn, 12'h002, 2'd0, 256'hA5, 1'b0);
      capture(0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL write t%0d ctl cyc %0d: got %b exp %b", t, i+1, obs_q[i].ctl, exp_q[i].ctl); end
        if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL write t%0d addr cyc %0d: got %h exp %h", t, i+1, obs_q[i].addr, exp_q[i].addr); end end
        n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL write t%0d rdata cyc %0d: got %h exp %h", t, i+1, obs_q[i].rdata, exp_q[i].rdata); end
        n_chk++; if (obs_q[i].dout !== exp_q[i].dout) begin n_fail++; $display("FAIL write t%0d dout cyc %0d: got %h exp %h", t, i+1, obs_q[i].dout, exp_q[i].dout); end
      end
    end
    n_chk++;
    if (obs_q[2].rdata !== 256'hA5) begin n_fail++; $display("FAIL write readback: got %h exp a5", obs_q[2].rdata); end
  endtask

  task automatic test_burst_read;
    cur_gen++;
    ref_mem.delete();
    model(0, 1'b0, MainMemEn, 12'h00A, 2'd1, '0);
    issue(0, 1'b0, MainMemEn, 12'h00A, 2'd1, '0, 1'b0);
    capture(0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL burst ctl cyc %0d: got %b exp %b", i+1, obs_q[i].ctl, exp_q[i].ctl); end
      if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL burst addr cyc %0d: got %h exp %h", i+1, obs_q[i].addr, exp_q[i].addr); end end
      n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL burst rdata cyc %0d: got %h exp %h", i+1, obs_q[i].rdata, exp_q[i].rdata); end
      n_chk++; if (obs_q[i].dout !== exp_q[i].dout) begin n_fail++; $display("FAIL burst dout cyc %0d: got %h exp %h", i+1, obs_q[i].dout, exp_q[i].dout); end
    end
    n_chk++; if (obs_q[2].rdata !== 256'h6) begin n_fail++; $display("FAIL burst beat0 data: got %h exp 6", obs_q[2].rdata); end
    n_chk++; if (obs_q[5].rdata !== 256'hd) begin n_fail++; $display("FAIL burst beat1 data: got %h exp d", obs_q[5].rdata); end
    n_chk++; if (obs_q[3].addr !== {MainMemEn, 12'h00B}) begin n_fail++; $display("FAIL burst beat1 addr: got %h exp %h", obs_q[3].addr, {MainMemEn, 12'h00B}); end
  endtask

  task automatic test_wait_states;
    for (int k = 1; k < 3; k++) begin
      logic [3:0]  dev = 4'($urandom);
      logic [11:0] a   = 12'($urandom);
      int lows = 0;
      model(k, 1'b0, dev, a, 2'd0, '0);
      issue(k, 1'b0, dev, a, 2'd0, '0, 1'b0);
      capture(k, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL wait W%0d ctl cyc %0d: got %b exp %b", ws(k), i+1, obs_q[i].ctl, exp_q[i].ctl); end
        if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL wait W%0d addr cyc %0d: got %h exp %h", ws(k), i+1, obs_q[i].addr, exp_q[i].addr); end end
        n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL wait W%0d rdata cyc %0d: got %h exp %h", ws(k), i+1, obs_q[i].rdata, exp_q[i].rdata); end
        if (!obs_q[i].ctl[3]) lows++;
      end
      n_chk++; if (lows !== 1) begin n_fail++; $display("FAIL wait W%0d strobe width: got %0d exp 1", ws(k), lows); end
      n_chk++; if (obs_q[ws(k) + 1].ctl[1] !== 1'b1) begin n_fail++; $display("FAIL wait W%0d resp cycle %0d: got %b exp 1", ws(k), ws(k) + 2, obs_q[ws(k) + 1].ctl[1]); end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] dev = 4'($urandom);
    model(0, 1'b0, dev, 12'hFFF, 2'd1, '0);
    issue(0, 1'b0, dev, 12'hFFF, 2'd1, '0, 1'b0);
    capture(0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL wrap ctl cyc %0d: got %b exp %b", i+1, obs_q[i].ctl, exp_q[i].ctl); end
      if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL wrap addr cyc %0d: got %h exp %h", i+1, obs_q[i].addr, exp_q[i].addr); end end
      n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL wrap rdata cyc %0d: got %h exp %h", i+1, obs_q[i].rdata, exp_q[i].rdata); end
    end
    n_chk++; if (obs_q[3].addr !== {dev, 12'h000}) begin n_fail++; $display("FAIL wrap beat1 addr: got %h exp %h", obs_q[3].addr, {dev, 12'h000}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   d1 = 4'($urandom), d2 = 4'($urandom);
    logic [11:0]  a1 = 12'($urandom), a2 = 12'($urandom);
    logic [255:0] w2 = {8{$urandom}};
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        model(0, 1'b0, d1, a1, 2'd3, '0);
        issue(0, 1'b0, d1, a1, 2'd3, '0, 1'b1);
        req_write = 1'b1; req_dev = d2; req_addr = a2; req_len = 2'($urandom); req_wdata = w2;
      end else begin
        model(0, 1'b1, d2, a2, 2'd0, w2);
        @(posedge Clk); #1;
        vld[0] = 1'b0;
      end
      capture(0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL b2b t%0d ctl cyc %0d: got %b exp %b", t, i+1, obs_q[i].ctl, exp_q[i].ctl); end
        if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL b2b t%0d addr cyc %0d: got %h exp %h", t, i+1, obs_q[i].addr, exp_q[i].addr); end end
        n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL b2b t%0d rdata cyc %0d: got %h exp %h", t, i+1, obs_q[i].rdata, exp_q[i].rdata); end
        n_chk++; if (obs_q[i].dout !== exp_q[i].dout) begin n_fail++; $display("FAIL b2b t%0d dout cyc %0d: got %h exp %h", t, i+1, obs_q[i].dout, exp_q[i].dout); end
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      int           k   = $urandom_range(0, 2);
      bit           wr  = 1'($urandom_range(0, 1));
      logic [3:0]   dev = ($urandom_range(0, 1) != 0) ? MainMemEn : AluEn;
      logic [11:0]  a   = 12'hFFE + 12'($urandom_range(0, 3));
      logic [1:0]   len = 2'($urandom);
      logic [255:0] wd  = {8{$urandom}};
      model(k, wr, dev, a, len, wd);
      issue(k, wr, dev, a, len, wd, 1'b0);
      capture(k, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (obs_q[i].ctl !== exp_q[i].ctl) begin n_fail++; $display("FAIL rand n%0d ctl cyc %0d: got %b exp %b", n, i+1, obs_q[i].ctl, exp_q[i].ctl); end
        if (chka_q[i]) begin n_chk++; if (obs_q[i].addr !== exp_q[i].addr) begin n_fail++; $display("FAIL rand n%0d addr cyc %0d: got %h exp %h", n, i+1, obs_q[i].addr, exp_q[i].addr); end end
        n_chk++; if (obs_q[i].rdata !== exp_q[i].rdata) begin n_fail++; $display("FAIL rand n%0d rdata cyc %0d: got %h exp %h", n, i+1, obs_q[i].rdata, exp_q[i].rdata); end
        n_chk++; if (obs_q[i].dout !== exp_q[i].dout) begin n_fail++; $display("FAIL rand n%0d dout cyc %0d: got %h exp %h", n, i+1, obs_q[i].dout, exp_q[i].dout); end
      end
    end
  endtask

  task automatic test_reset_abort;
    issue(0, 1'b0, MainMemEn, 12'h010, 2'd3, '0, 1'b0);
    n_chk++; if (nrd[0] !== 1'b0) begin n_fail++; $display("FAIL abort precondition nRead: got %b exp 0", nrd[0]); end
    #2 nReset = 1'b0;
    #1;
    n_chk++;
    if ({nrd[0], nwr[0], rv[0], rl[0]} !== 4'b1100) begin
      n_fail++; $display("FAIL abort strobes/resp: got %b exp 1100", {nrd[0], nwr[0], rv[0], rl[0]});
    end
    n_chk++;
    if ({adr[0], rdat[0], dout[0]} !== '0) begin
      n_fail++; $display("FAIL abort data: addr %h rdata %h dout %h exp all 0", adr[0], rdat[0], dout[0]);
    end
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    @(negedge Clk) nReset = 1'b1;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge Clk); #1; end
      n_chk++;
      if ({rdy[0], nrd[0], nwr[0], rv[0], rl[0]} !== 5'b11100) begin
        n_fail++; $display("FAIL abort idle cyc %0d ctl: got %b exp 11100", c, {rdy[0], nrd[0], nwr[0], rv[0], rl[0]});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin vld[k] = 1'b0; last_rd[k] = '0; end
    req_write = 1'b0; req_dev = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    test_reset();
    test_write();
    test_burst_read();
    test_wait_states();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Bus initiator that turns single requests from the execution unit into the active-low nRead/nWrite strobe protocol on the shared 256-bit memory bus. The responding devices (main memory, instruction memory, ALU blocks) act on negedge Clk. This block therefore drives address and strobes from posedge Clk and captures read data after a fixed number of cycles. It supports single-beat writes and 1–4 beat incrementing read bursts.

Parameters:
WAIT_STATES, 1, cycles the address is held after the strobe cycle before read data is captured (0..7)
DATA_W, 256, bus data width
ADDR_W, 16, bus address width; [15:12] device select, [11:0] word offset

Ports:
Clk  input  1  system clock; all state updates on posedge
nReset  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = write, 0 = read
req_dev  input  4  device select, driven onto address[15:12]
req_addr  input  12  starting word offset
req_len  input  2  read beats minus 1 (0..3); ignored for writes (always 1 beat)
req_wdata  input  256  write data
resp_valid  output  1  one-cycle pulse per completed beat
resp_rdata  output  256  captured read data; holds until next capture
resp_last  output  1  with resp_valid, marks final beat
address  output  16  bus address
nRead  output  1  bus read strobe, active-low
nWrite  output  1  bus write strobe, active-low
BusDataOut  output  256  write data to bus (device DataIn)
BusDataIn  input  256  read data from bus (device Dataout)

Behaviour:
- Reset (async, while nReset low): state IDLE, nRead=1, nWrite=1, address=0, BusDataOut=0, resp_valid=0, resp_last=0, resp_rdata=0, beat counter=0, wait counter=0.
- Reset mid-operation aborts immediately. Strobes deassert asynchronously and no resp_valid is produced for the aborted request.
- req_ready = 1 only in IDLE, including the first cycle after reset release. A request is accepted on a posedge with req_valid & req_ready. At acceptance, dev, addr, len, write and wdata are registered, so inputs may change afterwards.
- States: IDLE -> STROBE -> WAIT (skipped when WAIT_STATES=0) -> RESP -> STROBE (more beats) or IDLE.
- STROBE, exactly 1 cycle:
  - address = {dev, offset}.
  - Read: nRead=0. Write: nWrite=0 and BusDataOut=wdata.
  - Never both strobes low at once. Each strobe is low for exactly one cycle per beat, so the device sees exactly one negedge.
- WAIT, WAIT_STATES cycles: strobes high; address and BusDataOut held.
- Capture: on the posedge leaving the last STROBE/WAIT cycle of a read beat, resp_rdata <= BusDataIn. Writes do not alter resp_rdata.
- RESP, 1 cycle:
  - resp_valid=1 and strobes high.
  - resp_last=1 on the final beat, which is always the case for writes.
  - Then offset <= offset+1 modulo 4096. Dev is unchanged, so offset 0xFFF wraps to 0x000 within the same device.
- Latency: with WAIT_STATES=W and acceptance at edge 0, the first resp_valid is high in cycle W+2. Each further burst beat adds W+2 cycles. There is no back-pressure on resp; the consumer must take every pulse.
- BusDataOut returns to 0 when entering IDLE.
- address holds its last value in IDLE. With strobes high, devices ignore it.

Decomposition:
- Shared package (already holding the device-select constants, e.g. MainMemEn): add typedef enum mbm_state_t {IDLE, STROBE, WAIT, RESP}, localparam DEV_W=4 and OFFS_W=12, and a struct mem_req_t {write, dev, addr, len, wdata}.
- One sub-module, mbm_wait_timer: a loadable down-counter that produces a done flag, reused for the WAIT state. Everything else lives in mem_bus_master.

Test Plan:
- Reset: assert nReset low mid-burst -> nRead=nWrite=1 and address=0 immediately; after release req_ready=1 and no resp_valid.
- Single write: dev=MainMemEn, addr=2, wdata=256'hA5, W=1 -> nWrite low for exactly cycle 1 with address={MainMemEn,12'h002}; resp_valid+resp_last in cycle 3. A read of addr 2 then returns 256'hA5.
- Burst read: after memory reset, dev=MainMemEn, addr=10, len=1 -> two resp_valid pulses with rdata 256'h6 then 256'hd; resp_last only on the second. The address sequence is 0x00A then 0x00B.
- Wait states: W=0 vs W=3 on a single read -> resp_valid in cycle 2 vs cycle 5; the strobe stays one cycle wide in both cases.
- Wrap: read addr=12'hFFF, len=1 -> second beat address = {dev,12'h000}.
- Back-to-back: req_valid held high with two requests -> the second is accepted only in the IDLE cycle after the first resp_last. req_ready stays 0 for the whole burst, and the nRead and nWrite strobes are never low together.
